laser_line_scanner: RTL and testbench

LASER_LINE_SCANNER -- requirements
Module: laser_line_scanner

---
 rtl/laser_line_scanner.sv | 197 +++++++++++++++++++
 tb/tb_laser_line_scanner.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/laser_line_scanner.sv
// Laser line scanner: double-buffered line fetch from the frame buffer and a timed laser modulation scan.
// Optional checkerboard test pattern enabled by defining LASER_TEST_PATTERN_EN.
module laser_line_scanner #(
  parameter int NUM_COLS     = 320,
  parameter int NUM_ROWS     = 240,
  parameter int PIX_W        = 8,
  parameter int START_DELAY  = 200,
  parameter int PIXEL_CYCLES = 4,
  parameter int ADDR_W       = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              x_stb_async,
  input  logic [8:0]        next_row,
  input  logic              next_row_valid,
  input  logic [PIX_W-1:0]  threshold,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic [PIX_W-1:0]  rd_data,
  output logic              laser_on,
  output logic              line_active,
  output logic              underrun,
  output logic              scan_abort
`ifdef LASER_TEST_PATTERN_EN
  ,
  input  logic              test_pattern
`endif
);

  localparam int COL_W = $clog2(NUM_COLS);
  localparam int DLY_W = $clog2(START_DELAY + 1);
  localparam int SUB_W = $clog2(PIXEL_CYCLES + 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);
  localparam logic [DLY_W-1:0] LAST_DLY = DLY_W'(START_DELAY - 1);
  localparam logic [SUB_W-1:0] LAST_SUB = SUB_W'(PIXEL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DELAY, SCAN} state_t;

  state_t            state, state_next;
  logic [2:0]        stb_sync;
  logic              strobe;
  logic              fetching;
  logic [COL_W-1:0]  fetch_col;
  logic [ADDR_W-1:0] fetch_base;
  logic              front_sel, back_sel;
  logic [1:0]        buf_valid, buf_started;
  logic              back_done, row_ok, tp, start_line, late_fetch;
  logic [PIX_W-1:0]  mem [2][NUM_COLS];
  logic [DLY_W-1:0]  dly_cnt, dly_next;
  logic [SUB_W-1:0]  sub_cnt, sub_next;
  logic [COL_W-1:0]  scan_col, col_next, rd_col;
  logic              pix_hit, laser_next, abort_next, under_next;

  always_ff @(posedge clk) begin
    if (reset) stb_sync <= '0;
    else       stb_sync <= {stb_sync[1:0], x_stb_async};
  end
  assign strobe = stb_sync[1] & ~stb_sync[2];

`ifdef LASER_TEST_PATTERN_EN
  logic [8:0] back_row, disp_row;
  assign tp = test_pattern;
  always_ff @(posedge clk) begin
    if (reset) begin
      back_row <= '0;
      disp_row <= '0;
    end else if (strobe) begin
      disp_row <= back_row;
      back_row <= next_row;
    end
  end
`else
  assign tp = 1'b0;
`endif

  // An ack of the last column in the strobe cycle still counts as completing the old back buffer.
  assign back_sel   = ~front_sel;
  assign back_done  = buf_valid[back_sel] | (fetching & rd_ack & (fetch_col == LAST_COL));
  assign row_ok     = next_row_valid & (32'(next_row) < NUM_ROWS);
  assign start_line = back_done | tp;
  assign late_fetch = buf_started[back_sel] & ~back_done & ~tp;
  assign rd_req     = fetching;
  assign rd_addr    = fetch_base + ADDR_W'(fetch_col);

  always_ff @(posedge clk) begin
    if (reset) begin
      fetching    <= 1'b0;
      fetch_col   <= '0;
      fetch_base  <= '0;
      front_sel   <= 1'b0;
      buf_valid   <= '0;
      buf_started <= '0;
    end else if (strobe) begin
      front_sel              <= back_sel;
      buf_valid[back_sel]    <= back_done;
      buf_valid[front_sel]   <= 1'b0;
      buf_started[front_sel] <= row_ok;
      fetching               <= row_ok;
      fetch_col              <= '0;
      fetch_base             <= ADDR_W'(next_row) * ADDR_W'(NUM_COLS);
    end else if (fetching && rd_ack) begin
      if (fetch_col == LAST_COL) begin
        fetching            <= 1'b0;
        buf_valid[back_sel] <= 1'b1;
      end else begin
        fetch_col <= fetch_col + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && fetching && rd_ack) mem[back_sel][fetch_col] <= rd_data;
  end

  // Look one pixel ahead so the registered laser output lands on the pixel boundary.
  always_comb begin
    rd_col = scan_col;
    if (state == DELAY)
      rd_col = '0;
    else if (sub_cnt == LAST_SUB && scan_col != LAST_COL)
      rd_col = scan_col + COL_W'(1);
  end

`ifdef LASER_TEST_PATTERN_EN
  assign pix_hit = tp ? (rd_col[3] ^ disp_row[3]) : (mem[front_sel][rd_col] >= threshold);
`else
  assign pix_hit = mem[front_sel][rd_col] >= threshold;
`endif

  always_comb begin
    state_next = state;
    dly_next   = dly_cnt;
    sub_next   = sub_cnt;
    col_next   = scan_col;
    laser_next = 1'b0;
    abort_next = 1'b0;
    under_next = 1'b0;
    if (strobe) begin
      abort_next = (state != IDLE);
      under_next = late_fetch;
      dly_next   = '0;
      state_next = start_line ? DELAY : IDLE;
    end else begin
      case (state)
        DELAY: begin
          if (dly_cnt == LAST_DLY) begin
            state_next = SCAN;
            col_next   = '0;
            sub_next   = '0;
            laser_next = pix_hit;
          end else begin
            dly_next = dly_cnt + DLY_W'(1);
          end
        end
        SCAN: begin
          if (sub_cnt == LAST_SUB) begin
            sub_next = '0;
            if (scan_col == LAST_COL) begin
              state_next = IDLE;
            end else begin
              col_next   = scan_col + COL_W'(1);
              laser_next = pix_hit;
            end
          end else begin
            sub_next   = sub_cnt + SUB_W'(1);
            laser_next = pix_hit;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      dly_cnt    <= '0;
      sub_cnt    <= '0;
      scan_col   <= '0;
      laser_on   <= 1'b0;
      underrun   <= 1'b0;
      scan_abort <= 1'b0;
    end else begin
      state      <= state_next;
      dly_cnt    <= dly_next;
      sub_cnt    <= sub_next;
      scan_col   <= col_next;
      laser_on   <= laser_next;
      underrun   <= under_next;
      scan_abort <= abort_next;
    end
  end

  assign line_active = (state == SCAN);

endmodule

// File: tb/tb_laser_line_scanner.sv
// Directed bench for laser_line_scanner: reset, fetch, scan timing, abort, underrun and row bounds.
module tb_laser_line_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic        x_stb_async;
  logic [8:0]  next_row;
  logic        next_row_valid;
  logic [7:0]  threshold;
  logic        rd_req;
  logic [16:0] rd_addr;
  logic        rd_ack;
  logic [7:0]  rd_data;
  logic        laser_on, line_active, underrun, scan_abort;
  logic        ack_en, ack_force;
  int          errors = 0;
  int          checks = 0;
`ifdef LASER_TEST_PATTERN_EN
  logic        test_pattern;
`endif

  always #5 clk = ~clk;

  // Frame-buffer model: every pixel holds its column index (low 8 bits).
  assign rd_ack  = ack_force | (ack_en & rd_req);
  assign rd_data = 8'(rd_addr % 17'd320);

  laser_line_scanner #(
    .NUM_COLS(320), .NUM_ROWS(240), .PIX_W(8),
    .START_DELAY(200), .PIXEL_CYCLES(4), .ADDR_W(17)
  ) dut (
    .clk(clk), .reset(reset), .x_stb_async(x_stb_async),
    .next_row(next_row), .next_row_valid(next_row_valid), .threshold(threshold),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .laser_on(laser_on), .line_active(line_active),
    .underrun(underrun), .scan_abort(scan_abort)
`ifdef LASER_TEST_PATTERN_EN
    , .test_pattern(test_pattern)
`endif
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Returns at the falling edge just after the clock edge on which the strobe takes effect.
  task automatic strobe();
    x_stb_async = 1'b1;
    tick(3);
    x_stb_async = 1'b0;
  endtask

  initial begin
    reset = 1'b1; x_stb_async = 1'b0; next_row = '0; next_row_valid = 1'b0;
    threshold = 8'd100; ack_en = 1'b0; ack_force = 1'b0;
`ifdef LASER_TEST_PATTERN_EN
    test_pattern = 1'b0;
`endif
    tick(3);
    check("reset_rd_req", 32'(rd_req), 0);
    check("reset_rd_addr", 32'(rd_addr), 0);
    check("reset_laser", 32'(laser_on), 0);
    check("reset_active", 32'(line_active), 0);
    check("reset_underrun", 32'(underrun), 0);
    check("reset_abort", 32'(scan_abort), 0);
    reset = 1'b0;
    tick(2);

    // First strobe: nothing fetched yet, so no line and no underrun; row 5 fetch starts.
    next_row = 9'd5; next_row_valid = 1'b1;
    strobe();
    check("s1_underrun", 32'(underrun), 0);
    check("s1_active", 32'(line_active), 0);
    check("s1_rd_req", 32'(rd_req), 1);
    check("s1_rd_addr", 32'(rd_addr), 1600);
    ack_en = 1'b1;
    tick(330);
    check("s1_fetch_done", 32'(rd_req), 0);
    check("s1_laser_idle", 32'(laser_on), 0);

    // Second strobe: row 5 displayed, threshold 100 -> laser on for cols 100..255.
    strobe();
    check("s2_underrun", 32'(underrun), 0);
    check("s2_rd_addr", 32'(rd_addr), 1600);
    check("s2_laser_delay", 32'(laser_on), 0);
    tick(199);
    check("s2_delay_end", 32'(line_active), 0);
    tick(1);
    check("s2_scan_start", 32'(line_active), 1);
    check("s2_laser_col0", 32'(laser_on), 0);
    tick(399);
    check("s2_laser_col99", 32'(laser_on), 0);
    tick(1);
    check("s2_laser_col100", 32'(laser_on), 1);
    tick(623);
    check("s2_laser_col255", 32'(laser_on), 1);
    tick(1);
    check("s2_laser_col256", 32'(laser_on), 0);
    tick(255);
    check("s2_last_pixel", 32'(line_active), 1);
    tick(1);
    check("s2_line_end", 32'(line_active), 0);
    check("s2_laser_end", 32'(laser_on), 0);

    // Row 239 fetch covers 76480..76799 while the row 5 copy is scanned.
    next_row = 9'd239;
    strobe();
    check("r239_first_addr", 32'(rd_addr), 76480);
    tick(319);
    check("r239_last_addr", 32'(rd_addr), 76799);
    check("r239_last_req", 32'(rd_req), 1);
    tick(1);
    check("r239_req_drop", 32'(rd_req), 0);
    threshold = 8'd50;
    tick(177);
    check("pre_abort_laser", 32'(laser_on), 1);

    // Strobe 300 clocks into SCAN, next row 240 is out of range.
    next_row = 9'd240;
    strobe();
    check("abort_pulse", 32'(scan_abort), 1);
    check("abort_laser", 32'(laser_on), 0);
    check("abort_active", 32'(line_active), 0);
    check("abort_underrun", 32'(underrun), 0);
    check("r240_no_req", 32'(rd_req), 0);
    tick(1);
    check("abort_one_cycle", 32'(scan_abort), 0);
    tick(198);
    check("abort_delay_end", 32'(line_active), 0);
    tick(1);
    check("abort_rescan", 32'(line_active), 1);
    check("r240_still_no_req", 32'(rd_req), 0);
    tick(1281);
    check("abort_line_end", 32'(line_active), 0);

    // Fetch starved of acks until the next strobe -> one underrun.
    ack_en = 1'b0; threshold = 8'd0;
    next_row = 9'd10;
    strobe();
    check("u_first_underrun", 32'(underrun), 0);
    check("u_rd_addr10", 32'(rd_addr), 3200);
    tick(10);
    next_row = 9'd20;
    strobe();
    check("u_underrun", 32'(underrun), 1);
    check("u_active", 32'(line_active), 0);
    check("u_abort", 32'(scan_abort), 0);
    check("u_rd_addr20", 32'(rd_addr), 6400);
    check("u_rd_req", 32'(rd_req), 1);
    tick(1);
    check("u_one_cycle", 32'(underrun), 0);
    tick(300);
    check("u_laser_off", 32'(laser_on), 0);
    check("u_still_idle", 32'(line_active), 0);

    // Reset mid-fetch drops rd_req; a late ack afterwards is ignored.
    reset = 1'b1;
    tick(1);
    check("rst_mid_req", 32'(rd_req), 0);
    reset = 1'b0; ack_force = 1'b1;
    tick(3);
    check("late_ack_req", 32'(rd_req), 0);
    check("late_ack_addr", 32'(rd_addr), 0);
    ack_force = 1'b0;

`ifdef LASER_TEST_PATTERN_EN
    // Checkerboard on row 8: cols 0..7 on, cols 8..15 off, regardless of buffer state.
    test_pattern = 1'b1; next_row = 9'd8;
    strobe();
    next_row = 9'd0;
    tick(5);
    strobe();
    check("tp_underrun", 32'(underrun), 0);
    tick(200);
    check("tp_col0", 32'(laser_on), 1);
    tick(31);
    check("tp_col7", 32'(laser_on), 1);
    tick(1);
    check("tp_col8", 32'(laser_on), 0);
    tick(31);
    check("tp_col15", 32'(laser_on), 0);
    test_pattern = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
